regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter_if.sv | 32 +++
 rtl/regfile_wb_arbiter.sv | 76 +++++++
 tb/tb_regfile_wb_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: handshake and write-port bundle for the write-back arbiter
//   alu_*  : requester 0 valid/index/data in, ready out
//   lsu_*  : requester 1 valid/index/data in, ready out
//   wr_*   : registered register-file write port
//   conflict_cnt : saturating count of cycles with both valids high
//   modport slave  : arbiter side
//   modport master : producer / register-file side
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int IDX_W = 5
);
   logic alu_valid;
   logic [IDX_W-1:0] alu_index;
   logic [DATA_W-1:0] alu_data;
   logic alu_ready;
   logic lsu_valid;
   logic [IDX_W-1:0] lsu_index;
   logic [DATA_W-1:0] lsu_data;
   logic lsu_ready;
   logic wr_en;
   logic [IDX_W-1:0] wr_index;
   logic [DATA_W-1:0] wr_data;
   logic [15:0] conflict_cnt;
   modport slave (
      input alu_valid, alu_index, alu_data, lsu_valid, lsu_index, lsu_data,
      output alu_ready, lsu_ready, wr_en, wr_index, wr_data, conflict_cnt
   );
   modport master (
      output alu_valid, alu_index, alu_data, lsu_valid, lsu_index, lsu_data,
      input alu_ready, lsu_ready, wr_en, wr_index, wr_data, conflict_cnt
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between ALU and LSU
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : regfile_wb_arbiter_if.slave (handshakes, write port, conflict count)
//   WB_ARB_RR_EN defined selects round-robin; otherwise LSU-first with a
//   MAX_WAIT starvation bound on the ALU.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int IDX_W = 5,
   parameter int MAX_WAIT = 3
) (
   input logic clk,
   input logic reset_n,
   regfile_wb_arbiter_if.slave bus
);
   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
   logic [3:0] wait0_q, wait0_d, wait1_q, wait1_d;
   logic wr_en_q, wr_en_d;
   logic [IDX_W-1:0] wr_index_q, wr_index_d, sel_index;
   logic [DATA_W-1:0] wr_data_q, wr_data_d, sel_data;
   logic [15:0] cnt_q, cnt_d;
   logic grant0, grant1;
`ifdef WB_ARB_RR_EN
   logic last_q, last_d;
`endif
   always_comb begin
`ifdef WB_ARB_RR_EN
      // last_q=1 means the LSU won last, so the ALU takes the conflict
      grant0 = bus.alu_valid & (~bus.lsu_valid | last_q);
`else
      grant0 = bus.alu_valid & (~bus.lsu_valid | (wait0_q == MAX_W));
`endif
      grant1 = bus.lsu_valid & ~grant0;
      sel_index = grant0 ? bus.alu_index : bus.lsu_index;
      sel_data = grant0 ? bus.alu_data : bus.lsu_data;
      // writes to x0 are accepted but never reach the register file
      wr_en_d = (grant0 | grant1) & (sel_index != '0);
      wr_index_d = wr_en_d ? sel_index : wr_index_q;
      wr_data_d = wr_en_d ? sel_data : wr_data_q;
      wait0_d = (bus.alu_valid & ~grant0) ? ((wait0_q == MAX_W) ? wait0_q : wait0_q + 4'd1) : 4'd0;
      wait1_d = (bus.lsu_valid & ~grant1) ? ((wait1_q == MAX_W) ? wait1_q : wait1_q + 4'd1) : 4'd0;
      cnt_d = (bus.alu_valid & bus.lsu_valid & (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
`ifdef WB_ARB_RR_EN
      last_d = grant0 ? 1'b0 : (grant1 ? 1'b1 : last_q);
`endif
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait0_q <= '0;
         wait1_q <= '0;
         wr_en_q <= 1'b0;
         wr_index_q <= '0;
         wr_data_q <= '0;
         cnt_q <= '0;
`ifdef WB_ARB_RR_EN
         last_q <= 1'b1;
`endif
      end else begin
         wait0_q <= wait0_d;
         wait1_q <= wait1_d;
         wr_en_q <= wr_en_d;
         wr_index_q <= wr_index_d;
         wr_data_q <= wr_data_d;
         cnt_q <= cnt_d;
`ifdef WB_ARB_RR_EN
         last_q <= last_d;
`endif
      end
   end
   assign bus.alu_ready = grant0;
   assign bus.lsu_ready = grant1;
   assign bus.wr_en = wr_en_q;
   assign bus.wr_index = wr_index_q;
   assign bus.wr_data = wr_data_q;
   assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of grant policy, write port, x0, reset and saturation
module tb_regfile_wb_arbiter;
   logic clk = 1'b0;
   logic reset_n;
   int n_tests = 0;
   int n_fail = 0;
   int lcnt;
   logic [5:0] pat;
   regfile_wb_arbiter_if #(.DATA_W(32), .IDX_W(5)) bus ();
   regfile_wb_arbiter #(.DATA_W(32), .IDX_W(5), .MAX_WAIT(3)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   initial begin
      reset_n = 1'b0;
      bus.alu_valid = 1'b0;
      bus.alu_index = '0;
      bus.alu_data = '0;
      bus.lsu_valid = 1'b0;
      bus.lsu_index = '0;
      bus.lsu_data = '0;
      repeat (2) @(negedge clk);
      check("rst_wr_en", 64'(bus.wr_en), 64'd0);
      check("rst_wr_index", 64'(bus.wr_index), 64'd0);
      check("rst_wr_data", 64'(bus.wr_data), 64'd0);
      check("rst_cnt", 64'(bus.conflict_cnt), 64'd0);
      check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
      check("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
      reset_n = 1'b1;
      // continuous conflict from reset; bit i set means the ALU wins cycle i
`ifdef WB_ARB_RR_EN
      pat = 6'b010101;
`else
      pat = 6'b001000;
`endif
      bus.alu_valid = 1'b1;
      bus.alu_index = 5'd7;
      bus.alu_data = 32'hA0A0_0007;
      bus.lsu_valid = 1'b1;
      lcnt = 0;
      for (int i = 0; i < 6; i++) begin
         bus.lsu_index = 5'(8 + lcnt);
         bus.lsu_data = 32'h1000 + 32'(lcnt);
         #1;
         check($sformatf("conf_alu_ready_%0d", i), 64'(bus.alu_ready), 64'(pat[i]));
         check($sformatf("conf_lsu_ready_%0d", i), 64'(bus.lsu_ready), 64'(!pat[i]));
         @(negedge clk);
         check($sformatf("conf_wr_en_%0d", i), 64'(bus.wr_en), 64'd1);
         check($sformatf("conf_wr_index_%0d", i), 64'(bus.wr_index), pat[i] ? 64'd7 : 64'(8 + lcnt));
         check($sformatf("conf_wr_data_%0d", i), 64'(bus.wr_data), pat[i] ? 64'hA0A0_0007 : 64'(32'h1000 + 32'(lcnt)));
         if (!pat[i]) lcnt++;
      end
      bus.alu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      #1;
      check("conf_cnt", 64'(bus.conflict_cnt), 64'd6);
      check("idle_alu_ready", 64'(bus.alu_ready), 64'd0);
      check("idle_lsu_ready", 64'(bus.lsu_ready), 64'd0);
      // single ALU write
      bus.alu_valid = 1'b1;
      bus.alu_index = 5'd5;
      bus.alu_data = 32'hDEADBEEF;
      #1;
      check("single_alu_ready", 64'(bus.alu_ready), 64'd1);
      check("single_lsu_ready", 64'(bus.lsu_ready), 64'd0);
      @(negedge clk);
      bus.alu_valid = 1'b0;
      check("single_wr_en", 64'(bus.wr_en), 64'd1);
      check("single_wr_index", 64'(bus.wr_index), 64'd5);
      check("single_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
      @(negedge clk);
      check("single_wr_en_off", 64'(bus.wr_en), 64'd0);
      check("single_wr_index_hold", 64'(bus.wr_index), 64'd5);
      // write to x0 is accepted but suppressed
      bus.lsu_valid = 1'b1;
      bus.lsu_index = 5'd0;
      bus.lsu_data = 32'h1234;
      #1;
      check("x0_lsu_ready", 64'(bus.lsu_ready), 64'd1);
      @(negedge clk);
      bus.lsu_valid = 1'b0;
      check("x0_wr_en", 64'(bus.wr_en), 64'd0);
      check("x0_wr_index", 64'(bus.wr_index), 64'd5);
      check("x0_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
      check("x0_cnt", 64'(bus.conflict_cnt), 64'd6);
      // asynchronous reset with a conflict pending
      bus.alu_valid = 1'b1;
      bus.alu_index = 5'd3;
      bus.alu_data = 32'h33;
      bus.lsu_valid = 1'b1;
      bus.lsu_index = 5'd4;
      bus.lsu_data = 32'h44;
      @(negedge clk);
      check("pre_rst_wr_en", 64'(bus.wr_en), 64'd1);
      check("pre_rst_cnt", 64'(bus.conflict_cnt), 64'd7);
      #2 reset_n = 1'b0;
      #1;
      check("arst_wr_en", 64'(bus.wr_en), 64'd0);
      check("arst_wr_index", 64'(bus.wr_index), 64'd0);
      check("arst_wr_data", 64'(bus.wr_data), 64'd0);
      check("arst_cnt", 64'(bus.conflict_cnt), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
`ifdef WB_ARB_RR_EN
      check("post_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
      check("post_rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
`else
      check("post_rst_alu_ready", 64'(bus.alu_ready), 64'd0);
      check("post_rst_lsu_ready", 64'(bus.lsu_ready), 64'd1);
`endif
      // conflict counter saturation
      repeat (65534) @(negedge clk);
      check("sat_cnt_fffe", 64'(bus.conflict_cnt), 64'hFFFE);
      @(negedge clk);
      check("sat_cnt_ffff", 64'(bus.conflict_cnt), 64'hFFFF);
      repeat (4465) @(negedge clk);
      check("sat_cnt_hold", 64'(bus.conflict_cnt), 64'hFFFF);
      check("sat_wr_en", 64'(bus.wr_en), 64'd1);
      bus.alu_valid = 1'b0;
      bus.lsu_valid = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
